// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the immediate generator / instruction encoder pair.
// Holds the immSel type codes, the canonical NOP, the decoded field bundle
// and small immediate-range helpers used by the packer.
package instr_encoder_pkg;

  // immSel type codes, identical to the immediate generator's encoding
  typedef enum logic [1:0] {
    IMM_I   = 2'b00,
    IMM_S   = 2'b01,
    IMM_B   = 2'b10,
    IMM_INV = 2'b11
  } imm_sel_e;

  // addi x0, x0, 0 -- emitted in place of an unencodable word
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Decoded register/opcode fields that travel alongside the immediate
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
  } instr_fields_t;

  // True when v is the sign extension of its low 12 bits (I/S immediates)
  function automatic logic fits_simm12(input logic [31:0] v);
    return v == {{20{v[11]}}, v[11:0]};
  endfunction

  // True when v is the sign extension of its low 13 bits (B offsets)
  function automatic logic fits_simm13(input logic [31:0] v);
    return v == {{19{v[12]}}, v[12:0]};
  endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Purpose: combinational RV32 I/S/B field packer with immediate error check.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing register stage owns flow control.
// Optional IMM_RANGE_CHECK_EN: also flag immediates that do not fit the type.
module instr_encoder_imm_pack
  import instr_encoder_pkg::*;
(
  input  logic [1:0]    imm_sel,
  input  instr_fields_t fields,
  input  logic [31:0]   imm,
  output logic [31:0]   instr,
  output logic          err
);

  logic sel_err;
  logic range_err;

  // Scatter immediate bits into the slots each instruction format expects
  always_comb begin
    instr   = NOP_INSTR;
    sel_err = 1'b0;
    case (imm_sel_e'(imm_sel))
      IMM_I: begin
        instr = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
      end
      IMM_S: begin
        instr = {imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                 imm[4:0], fields.opcode};
      end
      IMM_B: begin
        instr = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                 imm[4:1], imm[11], fields.opcode};
      end
      IMM_INV: begin
        instr   = NOP_INSTR;
        sel_err = 1'b1;
      end
      default: begin
        instr   = NOP_INSTR;
        sel_err = 1'b1;
      end
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Flag immediates whose dropped upper bits would change the value
  always_comb begin
    range_err = 1'b0;
    case (imm_sel_e'(imm_sel))
      IMM_I, IMM_S: range_err = !fits_simm12(imm);
      IMM_B:        range_err = !fits_simm13(imm) || imm[0];
      default:      range_err = 1'b0;
    endcase
  end
`else
  // Without the check the upper immediate bits are simply discarded
  logic unused_imm_hi;
  assign range_err     = 1'b0;
  assign unused_imm_hi = ^imm[31:13];
`endif

  assign err = sel_err || range_err;

endmodule

// File: rtl/instr_encoder.sv
// Purpose: pack decoded fields + immediate into RV32 words tagged with imem address.
// Latency: 1 cycle from input transfer to out_valid (single output register).
// Backpressure: in_ready = !out_valid || out_ready; held word stays stable while stalled.
// Optional IMM_RANGE_CHECK_EN: out_err also reports out-of-range immediates.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        immSel,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [31:0]       imm,
  input  logic              load_addr,
  input  logic [ADDR_W-1:0] load_addr_val,
  input  logic              clr_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_sticky
);

  instr_fields_t     fields;
  logic [31:0]       packed_instr;
  logic              packed_err;
  logic [ADDR_W-1:0] addr_cnt;
  logic              in_xfer;

  assign fields = '{opcode: opcode, rd: rd, rs1: rs1, rs2: rs2, funct3: funct3};

  instr_encoder_imm_pack u_imm_pack (
    .imm_sel (immSel),
    .fields  (fields),
    .imm     (imm),
    .instr   (packed_instr),
    .err     (packed_err)
  );

  // The register frees up in the same cycle its word is taken downstream,
  // so a continuous stream moves one word per cycle.
  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;

  // Output register: capture on input transfer, drop valid once drained
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
      out_err   <= 1'b0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_instr <= packed_instr;
      out_addr  <= addr_cnt;
      out_err   <= packed_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Address counter: an explicit load beats the post-capture increment
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt <= '0;
    end else if (load_addr) begin
      addr_cnt <= load_addr_val;
    end else if (in_xfer) begin
      addr_cnt <= addr_cnt + ADDR_W'(1);
    end
  end

  // Sticky error: a newly captured bad word beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (in_xfer && packed_err) begin
      err_sticky <= 1'b1;
    end else if (clr_err) begin
      err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed spec vectors, then random traffic.
// Reference model packs by arithmetic shifts/masks and tracks one pending word.
// Honours IMM_RANGE_CHECK_EN the same way as the design build.
module tb_instr_encoder;
  localparam int ADDR_W = 10;
  localparam int AMAX   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        immSel;
  logic [6:0]        opcode;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        funct3;
  logic [31:0]       imm;
  logic              load_addr;
  logic [ADDR_W-1:0] load_addr_val;
  logic              clr_err;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic              err_sticky;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .immSel(immSel), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .imm(imm), .load_addr(load_addr),
    .load_addr_val(load_addr_val), .clr_err(clr_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_sticky(err_sticky)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_vld;
  logic [31:0] m_instr;
  int          m_addr;
  bit          m_err;
  bit          m_sticky;
  int          m_cnt;

  function automatic logic [31:0] ref_pack(input logic [1:0] sel, input logic [31:0] im,
                                           input logic [4:0] d, input logic [4:0] s1,
                                           input logic [4:0] s2, input logic [2:0] f3,
                                           input logic [6:0] op);
    logic [31:0] base;
    base = 32'(op) | (32'(f3) << 12) | (32'(s1) << 15);
    case (sel)
      2'd0: return base | (32'(d) << 7) | ((im & 32'hFFF) << 20);
      2'd1: return base | (32'(s2) << 20) | ((im & 32'h1F) << 7)
                        | (((im >> 5) & 32'h7F) << 25);
      2'd2: return base | (32'(s2) << 20) | (((im >> 11) & 32'h1) << 7)
                        | (((im >> 1) & 32'hF) << 8) | (((im >> 5) & 32'h3F) << 25)
                        | (((im >> 12) & 32'h1) << 31);
      default: return 32'h0000_0013;
    endcase
  endfunction

  function automatic bit ref_err(input logic [1:0] sel, input logic [31:0] im);
    int s;
    s = $signed(im);
    if (sel == 2'd3) return 1'b1;
`ifdef IMM_RANGE_CHECK_EN
    if (sel == 2'd2) return (s < -4096) || (s > 4095) || (s % 2 != 0);
    return (s < -2048) || (s > 2047);
`else
    if (s == 0) return 1'b0;
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: check in_ready, advance the model, then check registered outputs
  task automatic tick(input string tag);
    bit exp_rdy;
    bit xfer;
    bit e;
    #1;
    exp_rdy = !m_vld || out_ready;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    xfer = in_valid && exp_rdy;
    if (rst) begin
      m_vld = 0; m_instr = 0; m_addr = 0; m_err = 0; m_sticky = 0; m_cnt = 0;
    end else begin
      e = ref_err(immSel, imm);
      if (xfer) begin
        m_vld   = 1;
        m_instr = ref_pack(immSel, imm, rd, rs1, rs2, funct3, opcode);
        m_err   = e;
        m_addr  = m_cnt;
      end else if (out_ready) begin
        m_vld = 0;
      end
      if (xfer && e) m_sticky = 1;
      else if (clr_err) m_sticky = 0;
      if (load_addr) m_cnt = int'(load_addr_val);
      else if (xfer) m_cnt = (m_cnt + 1) % AMAX;
    end
    @(posedge clk);
    #1;
    check({tag, ".out_valid"},  32'(out_valid),  32'(m_vld));
    check({tag, ".out_instr"},  out_instr,       m_instr);
    check({tag, ".out_addr"},   32'(out_addr),   32'(m_addr));
    check({tag, ".out_err"},    32'(out_err),    32'(m_err));
    check({tag, ".err_sticky"}, 32'(err_sticky), 32'(m_sticky));
  endtask

  task automatic set_word(input logic [1:0] sel, input logic [31:0] im, input logic [4:0] d,
                          input logic [4:0] s1, input logic [4:0] s2,
                          input logic [2:0] f3, input logic [6:0] op);
    in_valid = 1'b1; immSel = sel; imm = im; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; opcode = op;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; immSel = 0; opcode = 0; rd = 0; rs1 = 0; rs2 = 0;
    funct3 = 0; imm = 0; load_addr = 0; load_addr_val = 0; clr_err = 0; out_ready = 1;
    m_vld = 0; m_instr = 0; m_addr = 0; m_err = 0; m_sticky = 0; m_cnt = 0;
    tick("reset0");
    tick("reset1");
    rst = 1'b0;
    tick("idle");

    // Spec packing vectors; unused fields randomised to show they are ignored
    set_word(2'd0, 32'd5, 5'd1, 5'd0, 5'($urandom), 3'd0, 7'h13);
    tick("tp_I");
    check("tp_I.lit", out_instr, 32'h0050_0093);
    set_word(2'd1, 32'd8, 5'($urandom), 5'd1, 5'd2, 3'd2, 7'h23);
    tick("tp_S");
    check("tp_S.lit", out_instr, 32'h0020_A423);
    set_word(2'd2, -32'sd4, 5'($urandom), 5'd1, 5'd2, 3'd0, 7'h63);
    tick("tp_B");
    check("tp_B.lit", out_instr, 32'hFE20_8EE3);
    set_word(2'd0, 32'd2048, 5'd1, 5'd0, 5'd0, 3'd0, 7'h13);
    tick("tp_rng");
    check("tp_rng.lit", out_instr, 32'h8000_0093);
    set_word(2'd3, 32'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'h33);
    tick("tp_inv");
    check("tp_inv.lit", out_instr, 32'h0000_0013);
    check("tp_inv.err", 32'(out_err), 32'd1);
    in_valid = 0; clr_err = 1;
    tick("clr");
    clr_err = 0;

    // Backpressure: hold one word for 5 cycles while the next waits
    out_ready = 0;
    set_word(2'd0, 32'd100, 5'd3, 5'd4, 5'd5, 3'd1, 7'h13);
    tick("bp_cap");
    set_word(2'd1, -32'sd16, 5'd0, 5'd6, 5'd7, 3'd2, 7'h23);
    for (int i = 0; i < 5; i++) begin
      tick("bp_hold");
      check("bp_hold.stable", out_instr, ref_pack(2'd0, 32'd100, 5'd3, 5'd4, 5'd5, 3'd1, 7'h13));
    end
    out_ready = 1;
    tick("bp_release");
    check("bp_next", out_instr, ref_pack(2'd1, -32'sd16, 5'd0, 5'd6, 5'd7, 3'd2, 7'h23));
    in_valid = 0;
    tick("bp_drain");

    // Address load, sequential increment and wrap
    load_addr = 1; load_addr_val = 10'h010;
    tick("ld10");
    load_addr = 0;
    for (int i = 0; i < 3; i++) begin
      set_word(2'd0, 32'(i), 5'd1, 5'd2, 5'd3, 3'd0, 7'h13);
      tick("seq");
      check("seq.addr", 32'(out_addr), 32'h10 + 32'(i));
    end
    in_valid = 0; load_addr = 1; load_addr_val = 10'h3FF;
    tick("ld3ff");
    load_addr = 0;
    set_word(2'd0, 32'd1, 5'd1, 5'd1, 5'd1, 3'd0, 7'h13);
    tick("wrap0");
    check("wrap0.addr", 32'(out_addr), 32'h3FF);
    tick("wrap1");
    check("wrap1.addr", 32'(out_addr), 32'h000);
    load_addr = 1; load_addr_val = 10'h055;
    tick("ldxfer");
    check("ldxfer.old", 32'(out_addr), 32'h001);
    load_addr = 0;
    tick("ldxfer_next");
    check("ldxfer.new", 32'(out_addr), 32'h055);

    // Reset while a bad word is pending downstream
    out_ready = 0;
    set_word(2'd3, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h13);
    tick("rst_pend");
    rst = 1; load_addr = 1; load_addr_val = 10'h077;
    tick("rst_mid");
    check("rst_mid.valid", 32'(out_valid), 32'd0);
    check("rst_mid.sticky", 32'(err_sticky), 32'd0);
    rst = 0; load_addr = 0; out_ready = 1;
    set_word(2'd0, 32'd7, 5'd2, 5'd2, 5'd2, 3'd0, 7'h13);
    tick("rst_after");
    check("rst_after.addr", 32'(out_addr), 32'h000);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      immSel    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      else imm = 32'($urandom);
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      funct3 = 3'($urandom); opcode = 7'($urandom);
      load_addr     = ($urandom_range(0, 15) == 0);
      load_addr_val = ADDR_W'($urandom);
      clr_err       = ($urandom_range(0, 7) == 0);
      rst           = ($urandom_range(0, 99) == 0);
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
